// File: rtl/rf_pkg.sv
// rf_pkg: shared clear-sequencer states and default register-file geometry.
package rf_pkg;
  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 32;
  typedef enum logic {IDLE, CLEAR} clrState_e;
endpackage

// File: rtl/rf_clear_seq.sv
// rf_clear_seq: on a clear request, steps an index over registers 1..DEPTH-1, one per cycle,
// then emits a one-cycle done pulse.
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clrReq,
  output logic          clrBusy,
  output logic          clrDone,
  output logic [AW-1:0] clrIdx
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  clrState_e state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      clrIdx <= AW'(1);
      clrBusy <= 1'b0;
      clrDone <= 1'b0;
    end else begin
      clrDone <= 1'b0;
      if (state == IDLE) begin
        if (clrReq) begin
          state <= CLEAR;
          clrBusy <= 1'b1;
          clrIdx <= AW'(1);
        end
      end else if (clrIdx == LAST) begin
        state <= IDLE;
        clrBusy <= 1'b0;
        clrDone <= 1'b1;
        clrIdx <= AW'(1);
      end else begin
        clrIdx <= clrIdx + AW'(1);
      end
    end
endmodule

// File: rtl/sync_reg_file.sv
// sync_reg_file: 2R1W register file, r0 hardwired to zero, registered reads, sequenced bulk clear.
// Define SYNC_REG_FILE_BYPASS_EN for write-first forwarding from the write port to the read ports.
module sync_reg_file
  import rf_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr1,
  input  logic [AW-1:0]    raddr2,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic             clr_done
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] clrIdx;
  logic wrEn, fwd1, fwd2;
  logic [WIDTH-1:0] rd1, rd2;
  rf_clear_seq #(.DEPTH(DEPTH)) uClearSeq (
    .clk,
    .rst_n,
    .clrReq(clr_req),
    .clrBusy(clr_busy),
    .clrDone(clr_done),
    .clrIdx
  );
  // mem[0] is only ever reset, so it reads back as zero without a special case
  assign wrEn = we && !clr_busy && waddr != '0 && 32'(waddr) < DEPTH;
`ifdef SYNC_REG_FILE_BYPASS_EN
  assign fwd1 = wrEn && waddr == raddr1;
  assign fwd2 = wrEn && waddr == raddr2;
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif
  always_comb begin
    rd1 = fwd1 ? wdata : 32'(raddr1) < DEPTH ? mem[raddr1] : '0;
    rd2 = fwd2 ? wdata : 32'(raddr2) < DEPTH ? mem[raddr2] : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata1 <= '0;
      rdata2 <= '0;
    end else begin
      if (wrEn) mem[waddr] <= wdata;
      if (clr_busy) mem[clrIdx] <= '0;
      rdata1 <= rd1;
      rdata2 <= rd2;
    end
endmodule

// File: tb/tb_sync_reg_file.sv
// tb_sync_reg_file: scoreboard bench for sync_reg_file (DEPTH=32 and DEPTH=20 instances share stimulus).
module tb_sync_reg_file;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic we = 1'b0;
  logic clr_req = 1'b0;
  logic [4:0] waddr = '0, raddr1 = '0, raddr2 = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata1, rdata2, rdata1_20, rdata2_20;
  logic clr_busy, clr_done, clr_busy_20, clr_done_20;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] mdl [32];
  logic [31:0] m20 [32];
  logic [31:0] expQ1 [$];
  logic [31:0] expQ2 [$];
  logic [31:0] exp1, exp2;

  always #5 clk = ~clk;

  sync_reg_file dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  sync_reg_file #(.DEPTH(20)) dut20 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_20), .rdata2(rdata2_20),
    .clr_req(clr_req), .clr_busy(clr_busy_20), .clr_done(clr_done_20)
  );

  task automatic drive(input logic iWe, input logic [4:0] iWa, input logic [31:0] iWd,
                       input logic [4:0] iR1, input logic [4:0] iR2, input logic iClr);
    we = iWe;
    waddr = iWa;
    wdata = iWd;
    raddr1 = iR1;
    raddr2 = iR2;
    clr_req = iClr;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2, input logic [31:0] e1, input logic [31:0] e2);
    drive(1'b0, 5'd0, 32'd0, a1, a2, 1'b0);
    expQ1.push_back(e1);
    expQ2.push_back(e2);
  endtask

  task automatic test_reset();
    drive(1'b1, 5'd4, 32'hBAD, 5'd4, 5'd4, 1'b1);
    repeat (2) @(negedge clk);
    vectors += 4;
    if (rdata1 !== 32'd0) begin miscompares++; $display("FAIL reset_rdata1 got=%h exp=0", rdata1); end
    if (rdata2 !== 32'd0) begin miscompares++; $display("FAIL reset_rdata2 got=%h exp=0", rdata2); end
    if (clr_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", clr_busy); end
    if (clr_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", clr_done); end
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    drive(1'b1, 5'd5, 32'h55, 5'd0, 5'd0, 1'b0);
    rst_n = 1'b1;
    mdl[5] = 32'h55;
    @(negedge clk);
    rd(5'd5, 5'd4, mdl[5], mdl[4]);
    @(negedge clk);
    exp1 = expQ1.pop_front();
    exp2 = expQ2.pop_front();
    vectors += 2;
    if (rdata1 !== exp1) begin miscompares++; $display("FAIL first_write got=%h exp=%h", rdata1, exp1); end
    if (rdata2 !== exp2) begin miscompares++; $display("FAIL reset_write_dropped got=%h exp=%h", rdata2, exp2); end
  endtask

  task automatic test_write_read();
    drive(1'b1, 5'd3, 32'h0000_00A5, 5'd0, 5'd0, 1'b0);
    mdl[3] = 32'h0000_00A5;
    @(negedge clk);
    rd(5'd3, 5'd3, mdl[3], mdl[3]);
    @(negedge clk);
    exp1 = expQ1.pop_front();
    exp2 = expQ2.pop_front();
    vectors += 2;
    if (rdata1 !== exp1) begin miscompares++; $display("FAIL r3_port1 got=%h exp=%h", rdata1, exp1); end
    if (rdata2 !== exp2) begin miscompares++; $display("FAIL r3_port2 got=%h exp=%h", rdata2, exp2); end
  endtask

  task automatic test_r0();
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b0);
    expQ1.push_back(32'd0);
    expQ2.push_back(32'd0);
    @(negedge clk);
    rd(5'd0, 5'd0, 32'd0, 32'd0);
    for (int k = 0; k < 2; k++) begin
      exp1 = expQ1.pop_front();
      exp2 = expQ2.pop_front();
      vectors += 2;
      if (rdata1 !== exp1) begin miscompares++; $display("FAIL r0_port1 k=%0d got=%h exp=%h", k, rdata1, exp1); end
      if (rdata2 !== exp2) begin miscompares++; $display("FAIL r0_port2 k=%0d got=%h exp=%h", k, rdata2, exp2); end
      if (k == 0) @(negedge clk);
    end
  endtask

  task automatic test_fill_read();
    logic [31:0] v;
    for (int i = 1; i < 32; i++) begin
      v = $urandom() | 32'h1;
      drive(1'b1, 5'(i), v, 5'd0, 5'd0, 1'b0);
      mdl[i] = v;
      @(negedge clk);
    end
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'((i * 7) % 32), mdl[i], mdl[(i * 7) % 32]);
      @(negedge clk);
      exp1 = expQ1.pop_front();
      exp2 = expQ2.pop_front();
      vectors += 2;
      if (rdata1 !== exp1) begin miscompares++; $display("FAIL fill_port1 a=%0d got=%h exp=%h", i, rdata1, exp1); end
      if (rdata2 !== exp2) begin miscompares++; $display("FAIL fill_port2 a=%0d got=%h exp=%h", (i * 7) % 32, rdata2, exp2); end
    end
  endtask

  task automatic test_bypass();
    logic [31:0] e;
    drive(1'b1, 5'd7, 32'h0000_0007, 5'd0, 5'd0, 1'b0);
    mdl[7] = 32'h0000_0007;
    @(negedge clk);
    drive(1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd7, 1'b0);
`ifdef SYNC_REG_FILE_BYPASS_EN
    e = 32'h1234_5678;
`else
    e = mdl[7];
`endif
    expQ1.push_back(e);
    expQ2.push_back(e);
    mdl[7] = 32'h1234_5678;
    @(negedge clk);
    rd(5'd7, 5'd3, mdl[7], mdl[3]);
    for (int k = 0; k < 2; k++) begin
      exp1 = expQ1.pop_front();
      exp2 = expQ2.pop_front();
      vectors += 2;
      if (rdata1 !== exp1) begin miscompares++; $display("FAIL bypass_port1 k=%0d got=%h exp=%h", k, rdata1, exp1); end
      if (rdata2 !== exp2) begin miscompares++; $display("FAIL bypass_port2 k=%0d got=%h exp=%h", k, rdata2, exp2); end
      if (k == 0) @(negedge clk);
    end
  endtask

  task automatic test_clear();
    int busyCnt, doneCnt, busy20Cnt;
    logic [31:0] old31;
    busyCnt = 0;
    doneCnt = 0;
    busy20Cnt = 0;
    old31 = mdl[31];
    drive(1'b1, 5'd9, 32'h99, 5'd31, 5'd9, 1'b1);
    @(negedge clk);
    for (int c = 0; c < 60; c++) begin
      if (expQ1.size() > 0) begin
        exp1 = expQ1.pop_front();
        exp2 = expQ2.pop_front();
        vectors += 2;
        if (rdata1 !== exp1) begin miscompares++; $display("FAIL clear_read_r31 c=%0d got=%h exp=%h", c, rdata1, exp1); end
        if (rdata2 !== exp2) begin miscompares++; $display("FAIL clear_read_r9 c=%0d got=%h exp=%h", c, rdata2, exp2); end
      end
      if (clr_busy) busyCnt++;
      if (clr_busy_20) busy20Cnt++;
      if (clr_done) begin
        doneCnt++;
        vectors++;
        if (clr_busy !== 1'b0) begin miscompares++; $display("FAIL done_with_busy got=%b exp=0", clr_busy); end
      end
      drive(c == 10, 5'd2, 32'hDEAD, 5'd31, 5'd9, c == 15);
      if (clr_busy) begin
        expQ1.push_back(old31);
        expQ2.push_back(c < 9 ? 32'h99 : 32'd0);
      end
      @(negedge clk);
    end
    vectors += 3;
    if (busyCnt != 31) begin miscompares++; $display("FAIL busy_cycles got=%0d exp=31", busyCnt); end
    if (doneCnt != 1) begin miscompares++; $display("FAIL done_pulses got=%0d exp=1", doneCnt); end
    if (busy20Cnt != 19) begin miscompares++; $display("FAIL busy_cycles_d20 got=%0d exp=19", busy20Cnt); end
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(31 - i), mdl[i], mdl[31 - i]);
      @(negedge clk);
      exp1 = expQ1.pop_front();
      exp2 = expQ2.pop_front();
      vectors += 2;
      if (rdata1 !== exp1) begin miscompares++; $display("FAIL cleared_port1 a=%0d got=%h exp=%h", i, rdata1, exp1); end
      if (rdata2 !== exp2) begin miscompares++; $display("FAIL cleared_port2 a=%0d got=%h exp=%h", 31 - i, rdata2, exp2); end
    end
  endtask

  task automatic test_clear_abort();
    int cnt, doneSeen, busySeen;
    logic [31:0] v;
    for (int i = 1; i < 32; i++) begin
      v = $urandom() | 32'h1;
      drive(1'b1, 5'(i), v, 5'd0, 5'd0, 1'b0);
      mdl[i] = v;
      @(negedge clk);
    end
    drive(1'b0, 5'd0, 32'd0, 5'd31, 5'd30, 1'b1);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 5'd31, 5'd30, 1'b0);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (clr_busy) cnt++;
      if (cnt == 10) break;
      @(negedge clk);
    end
    vectors++;
    if (cnt != 10) begin miscompares++; $display("FAIL abort_reach_cycle10 got=%0d exp=10", cnt); end
    rst_n = 1'b0;
    #1;
    vectors += 4;
    if (clr_busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got=%b exp=0", clr_busy); end
    if (clr_done !== 1'b0) begin miscompares++; $display("FAIL abort_done got=%b exp=0", clr_done); end
    if (rdata1 !== 32'd0) begin miscompares++; $display("FAIL abort_rdata1 got=%h exp=0", rdata1); end
    if (rdata2 !== 32'd0) begin miscompares++; $display("FAIL abort_rdata2 got=%h exp=0", rdata2); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    doneSeen = 0;
    busySeen = 0;
    repeat (5) begin
      @(negedge clk);
      if (clr_done) doneSeen++;
      if (clr_busy) busySeen++;
    end
    vectors += 2;
    if (doneSeen != 0) begin miscompares++; $display("FAIL abort_no_done got=%0d exp=0", doneSeen); end
    if (busySeen != 0) begin miscompares++; $display("FAIL abort_no_restart got=%0d exp=0", busySeen); end
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'((i + 16) % 32), mdl[i], mdl[(i + 16) % 32]);
      @(negedge clk);
      exp1 = expQ1.pop_front();
      exp2 = expQ2.pop_front();
      vectors += 2;
      if (rdata1 !== exp1) begin miscompares++; $display("FAIL abort_zero_port1 a=%0d got=%h exp=%h", i, rdata1, exp1); end
      if (rdata2 !== exp2) begin miscompares++; $display("FAIL abort_zero_port2 a=%0d got=%h exp=%h", (i + 16) % 32, rdata2, exp2); end
    end
  endtask

  task automatic test_depth20();
    for (int i = 0; i < 32; i++) m20[i] = '0;
    for (int i = 1; i < 20; i++) begin
      drive(1'b1, 5'(i), 32'hC0DE_0000 + 32'(i), 5'd0, 5'd0, 1'b0);
      m20[i] = 32'hC0DE_0000 + 32'(i);
      @(negedge clk);
    end
    drive(1'b1, 5'd25, 32'hDEAD_BEEF, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'd25, m20[i], 32'd0);
      @(negedge clk);
      exp1 = expQ1.pop_front();
      exp2 = expQ2.pop_front();
      vectors += 2;
      if (rdata1_20 !== exp1) begin miscompares++; $display("FAIL d20_read a=%0d got=%h exp=%h", i, rdata1_20, exp1); end
      if (rdata2_20 !== exp2) begin miscompares++; $display("FAIL d20_addr25 got=%h exp=%h", rdata2_20, exp2); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_r0();
    test_fill_read();
    test_bypass();
    test_clear();
    test_clear_abort();
    test_depth20();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
